// File: rtl/bcd_down_counter.sv
// Purpose : loadable multi-digit BCD down-counter with one-shot or auto-reload terminal count (auto-reload when BCD_DOWN_AUTO_RELOAD_EN is defined).
// Latency : 1 cycle for load, clear and each enabled decrement; look_ahead_borrow is combinational.
// Backpr. : none; count_enable qualifies each step, and gaps simply hold the count and state.
module bcd_down_counter #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sync_clr,
  input  logic                  sync_load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  count_enable,
  output logic [4*DIGITS-1:0]   BCD_count,
  output logic                  running,
  output logic                  done,
  output logic                  look_ahead_borrow
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNTING = 2'd1,
    ST_DONE     = 2'd2
  } state_t;

  state_t         state;
  logic [W-1:0]   load_clamped;
  logic [W-1:0]   count_dec;
  logic           count_is_one;
  logic           load_is_zero;

`ifdef BCD_DOWN_AUTO_RELOAD_EN
  // Preset kept so the terminal count can restart the period.
  logic [W-1:0]   preset_q;
`endif

  // Any preset digit above 9 is forced to 9 so the count stays valid BCD.
  function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
      else                    r[4*i +: 4] = v[4*i +: 4];
    end
    return r;
  endfunction

  // Digit-wise borrow chain: a digit steps only when every lower digit is 0.
  function automatic logic [W-1:0] dec_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Next-value helpers shared by the state register.
  always_comb begin
    load_clamped = clamp_bcd(load_value);
    count_dec    = dec_bcd(BCD_count);
    count_is_one = (BCD_count == W'(1));
    load_is_zero = (load_clamped == '0);
  end

  // Warn the controller one edge before terminal count is reached.
  assign look_ahead_borrow = count_enable && (state == ST_COUNTING) && count_is_one;

  // Control FSM with registered count, running and done; clear beats load beats enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      BCD_count <= '0;
      running   <= 1'b0;
      done      <= 1'b0;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
      preset_q  <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (sync_clr) begin
        state     <= ST_IDLE;
        BCD_count <= '0;
        running   <= 1'b0;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
        preset_q  <= '0;
`endif
      end else if (sync_load) begin
        BCD_count <= load_clamped;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
        preset_q  <= load_clamped;
`endif
        if (load_is_zero) begin
          state   <= ST_IDLE;
          running <= 1'b0;
        end else begin
          state   <= ST_COUNTING;
          running <= 1'b1;
        end
      end else if ((state == ST_COUNTING) && count_enable) begin
        if (count_is_one) begin
          done <= 1'b1;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
          // Restart the period from the held preset; stay in COUNTING.
          BCD_count <= preset_q;
`else
          BCD_count <= '0;
          state     <= ST_DONE;
          running   <= 1'b0;
`endif
        end else begin
          BCD_count <= count_dec;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Purpose : randomized and directed bench for bcd_down_counter against a decimal reference model.
// Latency : expectations are queued at stimulus time and compared one edge later by the monitor.
// Backpr. : none; the DUT presents an output every cycle.
module tb_bcd_down_counter;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic           clk;
  logic           reset;
  logic           sync_clr;
  logic           sync_load;
  logic [W-1:0]   load_value;
  logic           count_enable;
  logic [W-1:0]   BCD_count;
  logic           running;
  logic           done;
  logic           look_ahead_borrow;

  bcd_down_counter #(.DIGITS(DIGITS)) dut (
    .clk               (clk),
    .reset             (reset),
    .sync_clr          (sync_clr),
    .sync_load         (sync_load),
    .load_value        (load_value),
    .count_enable      (count_enable),
    .BCD_count         (BCD_count),
    .running           (running),
    .done              (done),
    .look_ahead_borrow (look_ahead_borrow)
  );

  typedef struct {
    logic [W-1:0] cnt;
    logic         run;
    logic         dn;
  } exp_t;

  exp_t exp_q[$];
  logic lab_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: count and preset as plain decimal integers.
  localparam int M_IDLE = 0, M_CNT = 1, M_DONE = 2;
  int m_cnt, m_pre, m_st;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int clamp_val(input logic [W-1:0] raw);
    int v, p, d;
    v = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(raw[4*i +: 4]);
      if (d > 9) d = 9;
      v = v + d * p;
      p = p * 10;
    end
    return v;
  endfunction

  function automatic void model_reset();
    m_cnt = 0;
    m_pre = 0;
    m_st  = M_IDLE;
  endfunction

  // Drive one cycle of stimulus and queue what the DUT must show.
  task automatic step(input bit clr, input bit ld, input logic [W-1:0] val, input bit en);
    exp_t e;
    bit   lab;
    bit   dn;
    @(negedge clk);
    sync_clr     = clr;
    sync_load    = ld;
    load_value   = val;
    count_enable = en;
    lab = en && (m_st == M_CNT) && (m_cnt == 1);
    lab_q.push_back(lab);
    dn = 1'b0;
    if (clr) begin
      m_cnt = 0; m_pre = 0; m_st = M_IDLE;
    end else if (ld) begin
      m_cnt = clamp_val(val);
      m_pre = m_cnt;
      m_st  = (m_cnt != 0) ? M_CNT : M_IDLE;
    end else if (m_st == M_CNT && en) begin
      if (m_cnt == 1) begin
        dn = 1'b1;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
        m_cnt = m_pre;
`else
        m_cnt = 0;
        m_st  = M_DONE;
`endif
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
    e.cnt = to_bcd(m_cnt);
    e.run = (m_st == M_CNT);
    e.dn  = dn;
    exp_q.push_back(e);
  endtask

  // Monitor: look-ahead checked mid-cycle, registered outputs just after the edge.
  initial begin
    exp_t e;
    logic l;
    forever begin
      @(negedge clk);
      #2;
      if (lab_q.size() > 0) begin
        l = lab_q.pop_front();
        chk("look_ahead_borrow", 32'(look_ahead_borrow), 32'(l));
      end
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("BCD_count", 32'(BCD_count), 32'(e.cnt));
        chk("running",   32'(running),   32'(e.run));
        chk("done",      32'(done),      32'(e.dn));
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    reset        = 1'b1;
    sync_clr     = 1'b0;
    sync_load    = 1'b0;
    load_value   = '0;
    count_enable = 1'b1;
    model_reset();

    // Reset state, with enable high to show look-ahead is suppressed.
    #12;
    chk("reset_count",   32'(BCD_count),         32'h0);
    chk("reset_running", 32'(running),           32'h0);
    chk("reset_done",    32'(done),              32'h0);
    chk("reset_lab",     32'(look_ahead_borrow), 32'h0);
    @(negedge clk);
    reset        = 1'b0;
    count_enable = 1'b0;

    // 3,2,1,0 countdown, then hold.
    step(0, 1, 16'h0003, 1);
    repeat (5) step(0, 0, 16'h0, 1);

    // Borrow ripple and digit clamp.
    step(0, 1, 16'h1000, 0);
    step(0, 0, 16'h0, 1);
    step(0, 1, 16'h00A5, 0);
    step(0, 1, 16'hFAF9, 1);
    step(0, 0, 16'h0, 1);

    // Load beats enable, then clear beats everything.
    step(0, 1, 16'h0002, 0);
    step(0, 1, 16'h0007, 1);
    step(0, 0, 16'h0, 0);
    step(1, 1, 16'h0009, 1);
    step(0, 0, 16'h0, 1);

    // Load on the terminal-count edge wins.
    step(0, 1, 16'h0001, 0);
    step(0, 1, 16'h0006, 1);
    step(0, 0, 16'h0, 1);

    // Enable gaps: done after exactly 5 enabled cycles.
    step(0, 1, 16'h0005, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 16'h0, (i % 2) == 1);

    // Asynchronous reset mid-count at 3.
    step(0, 1, 16'h0005, 0);
    k = 0;
    while (m_cnt != 3 && k < 20) begin
      step(0, 0, 16'h0, (k % 2) == 1);
      k++;
    end
    @(posedge clk);
    #3;
    chk("pre_reset_count", 32'(BCD_count), 32'h3);
    count_enable = 1'b1;
    reset = 1'b1;
    #1;
    chk("async_count",   32'(BCD_count),         32'h0);
    chk("async_running", 32'(running),           32'h0);
    chk("async_done",    32'(done),              32'h0);
    chk("async_lab",     32'(look_ahead_borrow), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (3) step(0, 0, 16'h0, 1);

    // Terminal-count behaviour over several periods (one-shot or reload).
    step(0, 1, 16'h0004, 0);
    repeat (13) step(0, 0, 16'h0, 1);
    step(0, 1, 16'h0001, 0);
    repeat (4) step(0, 0, 16'h0, 1);

    // Zero load stays idle under enable.
    step(0, 1, 16'h0000, 0);
    repeat (4) step(0, 0, 16'h0, 1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      bit           c, l, e;
      logic [W-1:0] v;
      c = ($urandom_range(0, 39) == 0);
      l = ($urandom_range(0, 11) == 0);
      e = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) v = W'($urandom);
      else                           v = to_bcd($urandom_range(0, 14));
      step(c, l, v, e);
    end

    repeat (3) @(negedge clk);
    chk("queue_drain", 32'(exp_q.size() + lab_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_down_counter.md
# bcd_down_counter

Multi-digit, loadable BCD down-counter for countdown timers. It is the decrementing counterpart of the lab BCD up-counter: digit-wise borrow instead of carry, and a look-ahead terminal-count flag instead of a look-ahead roll-over. It sits between the front-panel preset logic (load value) and the seven-segment display path (`BCD_count`). The controller above it consumes `done` and `look_ahead_borrow`.

## Interface
- `DIGITS`, default 4: number of BCD digits; legal range 1–8.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high reset.
- `sync_clr`  in  1: synchronous clear.
- `sync_load`  in  1: synchronous load of `load_value`.
- `load_value`  in  4*DIGITS: preset value, packed BCD, digit 0 in bits [3:0].
- `count_enable`  in  1: decrement qualifier, one step per enabled cycle.
- `BCD_count`  out  4*DIGITS: current count, packed BCD, registered.
- `running`  out  1: high while in the COUNTING state, registered.
- `done`  out  1: one-cycle terminal-count pulse, registered.
- `look_ahead_borrow`  out  1: combinational; the next clock edge reaches terminal count.

## Operation
- States:
  - IDLE: count is 0 or a zero load occurred.
  - COUNTING: decrementing.
  - DONE: expired, count held at 0.
- Input priority per edge: `sync_clr` > `sync_load` > `count_enable`.
- `sync_clr`: count set to 0, held preset set to 0, state to IDLE, `done` 0.
- `sync_load`:
  - Each digit > 9 is clamped to 9 before storing.
  - The sanitized value goes to both `BCD_count` and the internal held preset.
  - State becomes COUNTING if the value is nonzero, else IDLE. `done` is 0.
  - `sync_load` is honored in every state.
- Decrement (COUNTING and `count_enable`):
  - Digit i decrements if all digits below i equal 0.
  - A decrementing digit at 0 wraps to 9; digit 0 always decrements.
  - `BCD_count` is never non-BCD.
- Terminal count: when COUNTING, `count_enable`=1 and `BCD_count`==1:
  - next count = 0, state becomes DONE, `done`=1 for exactly that following cycle.
- IDLE and DONE: `count_enable` is ignored and the count holds.
- `look_ahead_borrow` = `count_enable` && state==COUNTING && `BCD_count`==1. It is 0 in all other cases.
- `running` = (state==COUNTING).

## Timing
- Reset values: `BCD_count`=0, `running`=0, `done`=0, state IDLE, held preset 0. `look_ahead_borrow`=0 while in reset.
- Load latency: 1 cycle; the loaded value is visible on the edge after `sync_load`.
- Count latency: 1 cycle per enabled step. A preset of N yields `done` exactly N enabled cycles after the load edge.
- `done` asserts in the same cycle `BCD_count` first shows the terminal value. It deasserts the next cycle regardless of inputs.
- `sync_load` and `count_enable` high together: the load wins and no decrement occurs that cycle.
- `sync_load` on the terminal-count edge: the load wins and `done` stays 0.
- Asynchronous `reset` mid-count forces all outputs to reset values immediately. Counting resumes only after a new load.
- Enable gaps pause the count; the count holds with no state change.

## Configuration
- `BCD_DOWN_AUTO_RELOAD_EN` defined:
  - At terminal count, the next count is the held preset instead of 0.
  - State stays COUNTING and `done` pulses for one cycle.
  - `BCD_count` never shows 0 unless cleared or loaded with 0. The period is exactly held-preset enabled cycles.
  - Preset 1 gives `done` on every enabled cycle.
- Not defined: one-shot behaviour as in Operation; DONE persists until `sync_load`, `sync_clr` or `reset`.

## Test plan
- DIGITS=4, load 0x0003, `count_enable` held high:
  - Count goes 3, 2, 1, 0.
  - `look_ahead_borrow` is high only while count=1.
  - `done` is high one cycle with count=0, then `running`=0.
- Load 0x1000, one enabled step: count becomes 0x0999 (borrow ripples through three digits). Load 0x00A5: count becomes 0x0095 (clamp).
- Load 0x0002, then assert `sync_load` (0x0007) and `count_enable` in the same cycle: count=7 with no decrement. Then pulse `sync_clr`: count 0, state IDLE, `done` 0.
- Load 0x0005, toggle `count_enable` every other cycle: `done` arrives after exactly 5 enabled cycles (10 clocks). Assert `reset` at count=3: outputs go to 0 asynchronously.
- With `BCD_DOWN_AUTO_RELOAD_EN`, load 0x0004, enable held high: count cycles 4, 3, 2, 1, 4, 3, … with `done` pulsing every 4 cycles. Without the macro, count stays 0 after the first pulse.
- Load 0x0000: state IDLE, `running`=0, `done` never asserts, `look_ahead_borrow` stays 0 under enable.
